// File: rtl/gba_sound_dma_pkg.sv
// Shared types and helpers for the multi-channel Direct Sound DMA block.
package gba_sound_dma_pkg;
    localparam int SAMPLE_W = 8;
    localparam int OUT_W    = 16;
    localparam int MIX_W    = 18;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [OUT_W-1:0]    out_t;
    typedef logic signed [MIX_W-1:0]    mix_t;

    typedef struct packed {
        logic        en;
        logic [1:0]  ch;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_req_t;

    localparam mix_t MIX_MAX = 18'sd32767;
    localparam mix_t MIX_MIN = -18'sd32768;

    // x4 for full volume, x2 for half volume
    function automatic out_t scale(sample_t s, logic hi);
        return hi ? {{6{s[7]}}, s, 2'b00} : {{7{s[7]}}, s, 1'b0};
    endfunction

    function automatic out_t sat16(mix_t m);
        if (m > MIX_MAX) return 16'sh7FFF;
        if (m < MIX_MIN) return 16'sh8000;
        return m[OUT_W-1:0];
    endfunction
endpackage

// File: rtl/gba_sound_dma_multi_if.sv
// FIFO word-write bus from CPU/DMA into the sound block.
interface gba_sound_dma_multi_if;
    logic        wr_en;
    logic [1:0]  wr_ch;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    modport master (output wr_en, wr_ch, wr_data, wr_be);
    modport slave  (input  wr_en, wr_ch, wr_data, wr_be);
endinterface

// File: rtl/gba_sound_dma_multi_fifo_ch.sv
// One Direct Sound channel: word FIFO, tick pending, byte unpack, scaling, refill request.
// Optional SOUND_DMA_STATS_EN adds underrun counter and sticky overflow flag.
module gba_sound_fifo_ch
    import gba_sound_dma_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int DMA_LEVEL = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          tick,
    input  logic          frst,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    input  logic [3:0]    wr_be,
    input  logic          vol_high,
    output out_t          sample,
    output logic          new_sample,
    output logic          dma_req,
    output logic [CW-1:0] count
`ifdef SOUND_DMA_STATS_EN
    ,
    output logic [7:0]    underrun_cnt,
    output logic          overflow
`endif
);
    logic [31:0]   mem [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] base_q, base_d, wr_addr;
    logic [1:0]    idx_q, idx_d;
    logic [31:0]   unpack_q, unpack_d;
    logic          pend_q, pend_d, new_q, new_d, dma_q, dma_d;
    out_t          sample_q, sample_d;
    logic          service, pop, ovf, mem_we;
`ifdef SOUND_DMA_STATS_EN
    logic [7:0]    und_q, und_d;
    logic          ovf_q, ovf_d;
`endif

    always_comb begin
        // a FIFO reset defers the service; the pending tick is taken next cycle
        service  = pend_q & ~frst;
        pop      = service & (idx_q == 2'd3) & (count_q != '0);
        ovf      = wr_en & (count_q == CW'(DEPTH));
        mem_we   = wr_en & ~frst;
        wr_addr  = ovf ? '0 : base_q + count_q[AW-1:0];
        pend_d   = tick | (pend_q & frst);
        new_d    = service;
        dma_d    = service & (count_q < CW'(DMA_LEVEL));
        idx_d    = idx_q;
        unpack_d = unpack_q;
        if (service) begin
            if (idx_q != 2'd3) idx_d = idx_q + 2'd1;
            else if (pop) begin
                unpack_d = mem[base_q];
                idx_d    = '0;
            end
        end
        base_d  = base_q + AW'(pop);
        count_d = count_q + CW'(wr_en) - CW'(pop);
        if (frst) begin
            count_d  = '0;
            base_d   = '0;
            idx_d    = '0;
            unpack_d = unpack_q;
        end else if (ovf) begin
            count_d = CW'(1);
            base_d  = '0;
        end
        sample_d = scale(sample_t'(unpack_q[{idx_q, 3'b000} +: 8]), vol_high);
`ifdef SOUND_DMA_STATS_EN
        und_d = und_q;
        ovf_d = ovf_q;
        if (frst) begin
            und_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (service && count_q == '0 && und_q != 8'hFF) und_d = und_q + 8'd1;
            if (ovf) ovf_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            for (int b = 0; b < 4; b++)
                if (wr_be[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            base_q   <= '0;
            idx_q    <= '0;
            unpack_q <= '0;
            pend_q   <= 1'b0;
            new_q    <= 1'b0;
            dma_q    <= 1'b0;
            sample_q <= '0;
`ifdef SOUND_DMA_STATS_EN
            und_q    <= '0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            count_q  <= count_d;
            base_q   <= base_d;
            idx_q    <= idx_d;
            unpack_q <= unpack_d;
            pend_q   <= pend_d;
            new_q    <= new_d;
            dma_q    <= dma_d;
            sample_q <= sample_d;
`ifdef SOUND_DMA_STATS_EN
            und_q    <= und_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign sample     = sample_q;
    assign new_sample = new_q;
    assign dma_req    = dma_q;
    assign count      = count_q;
`ifdef SOUND_DMA_STATS_EN
    assign underrun_cnt = und_q;
    assign overflow     = ovf_q;
`endif
endmodule

// File: rtl/gba_sound_dma_multi.sv
// NUM_CH Direct Sound channels with write decode, tick select and saturating stereo mix.
// Optional SOUND_DMA_STATS_EN exposes per-channel underrun/overflow statistics.
module gba_sound_dma_multi
    import gba_sound_dma_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int DEPTH     = 8,
    parameter int DMA_LEVEL = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    gba_sound_dma_multi_if.slave    wr,
    input  logic                    settings_new,
    input  logic [NUM_CH-1:0]       fifo_reset,
    input  logic [NUM_CH-1:0]       en_left,
    input  logic [NUM_CH-1:0]       en_right,
    input  logic [NUM_CH-1:0]       timer_sel,
    input  logic [NUM_CH-1:0]       volume_high,
    input  logic                    timer0_tick,
    input  logic                    timer1_tick,
    output logic [NUM_CH-1:0]       dma_req,
    output logic [NUM_CH-1:0]       new_sample,
    output logic [NUM_CH-1:0][15:0] sample_out,
    output out_t                    sound_left,
    output out_t                    sound_right,
    output logic [NUM_CH-1:0][3:0]  fifo_count
`ifdef SOUND_DMA_STATS_EN
    ,
    output logic [NUM_CH-1:0][7:0]  underrun_cnt,
    output logic [NUM_CH-1:0]       overflow
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;

    wr_req_t req;
    mix_t    left_d, right_d;
    out_t    sound_left_q, sound_right_q;

    assign req = '{en: wr.wr_en, ch: wr.wr_ch, data: wr.wr_data, be: wr.wr_be};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic          tick, frst, we;
        logic [CW-1:0] cnt;
        out_t          smp;

        assign tick = (en_left[c] | en_right[c]) & (timer_sel[c] ? timer1_tick : timer0_tick);
        assign frst = settings_new & fifo_reset[c];
        assign we   = req.en & (req.ch == 2'(c));

        gba_sound_fifo_ch #(.DEPTH(DEPTH), .DMA_LEVEL(DMA_LEVEL)) u_ch (
            .clk          (clk),
            .reset_n      (reset_n),
            .tick         (tick),
            .frst         (frst),
            .wr_en        (we),
            .wr_data      (req.data),
            .wr_be        (req.be),
            .vol_high     (volume_high[c]),
            .sample       (smp),
            .new_sample   (new_sample[c]),
            .dma_req      (dma_req[c]),
            .count        (cnt)
`ifdef SOUND_DMA_STATS_EN
            ,
            .underrun_cnt (underrun_cnt[c]),
            .overflow     (overflow[c])
`endif
        );

        assign sample_out[c] = smp;
        assign fifo_count[c] = 4'(cnt);
    end

    // sum at 18 bits so up to four full-scale channels never wrap before clamping
    always_comb begin
        left_d  = '0;
        right_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (en_left[c])  left_d  = left_d  + mix_t'({{2{sample_out[c][15]}}, sample_out[c]});
            if (en_right[c]) right_d = right_d + mix_t'({{2{sample_out[c][15]}}, sample_out[c]});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sound_left_q  <= '0;
            sound_right_q <= '0;
        end else begin
            sound_left_q  <= sat16(left_d);
            sound_right_q <= sat16(right_d);
        end
    end

    assign sound_left  = sound_left_q;
    assign sound_right = sound_right_q;
endmodule

// File: tb/tb_gba_sound_dma_multi.sv
// Directed bench for gba_sound_dma_multi with a queue-based per-cycle reference model.
module tb_gba_sound_dma_multi;
    localparam int NCH = 2;
    localparam int DEPTH = 8;
    localparam int LVL = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic settings_new = 1'b0;
    logic [NCH-1:0] fifo_reset = '0, en_left = '0, en_right = '0, timer_sel = '0, volume_high = '0;
    logic timer0_tick = 1'b0, timer1_tick = 1'b0;
    logic [NCH-1:0] dma_req, new_sample;
    logic [NCH-1:0][15:0] sample_out;
    logic signed [15:0] sound_left, sound_right;
    logic [NCH-1:0][3:0] fifo_count;
`ifdef SOUND_DMA_STATS_EN
    logic [NCH-1:0][7:0] underrun_cnt;
    logic [NCH-1:0] overflow;
`endif

    gba_sound_dma_multi_if wif();

    gba_sound_dma_multi #(.NUM_CH(NCH), .DEPTH(DEPTH), .DMA_LEVEL(LVL)) dut (
        .clk(clk), .reset_n(reset_n), .wr(wif.slave), .settings_new(settings_new),
        .fifo_reset(fifo_reset), .en_left(en_left), .en_right(en_right), .timer_sel(timer_sel),
        .volume_high(volume_high), .timer0_tick(timer0_tick), .timer1_tick(timer1_tick),
        .dma_req(dma_req), .new_sample(new_sample), .sample_out(sample_out),
        .sound_left(sound_left), .sound_right(sound_right), .fifo_count(fifo_count)
`ifdef SOUND_DMA_STATS_EN
        , .underrun_cnt(underrun_cnt), .overflow(overflow)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] mq [NCH][$];
    logic [31:0] m_cur [NCH];
    int  m_idx [NCH];
    bit  m_pend [NCH];
    int  e_samp [NCH];
    bit  e_new [NCH], e_dma [NCH], e_ovf [NCH];
    int  e_und [NCH];
    int  e_l = 0, e_r = 0;

    function automatic int scaled(logic [31:0] w, int idx, logic hi);
        logic signed [7:0] b;
        b = w[idx*8 +: 8];
        return hi ? int'(b) * 4 : int'(b) * 2;
    endfunction

    function automatic int clamp(int v);
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < NCH; c++) begin
                mq[c].delete();
                m_cur[c] = '0; m_idx[c] = 0; m_pend[c] = 0; e_samp[c] = 0;
                e_new[c] = 0; e_dma[c] = 0; e_ovf[c] = 0; e_und[c] = 0;
            end
            e_l = 0; e_r = 0;
        end else begin
            int l, r;
            l = 0; r = 0;
            for (int c = 0; c < NCH; c++) begin
                if (en_left[c])  l += e_samp[c];
                if (en_right[c]) r += e_samp[c];
            end
            e_l = clamp(l); e_r = clamp(r);
            for (int c = 0; c < NCH; c++) begin
                bit tk, fr, wr, srv;
                int pre;
                tk  = (en_left[c] | en_right[c]) && (timer_sel[c] ? timer1_tick : timer0_tick);
                fr  = settings_new && fifo_reset[c];
                wr  = wif.wr_en && (int'(wif.wr_ch) == c);
                pre = mq[c].size();
                e_samp[c] = scaled(m_cur[c], m_idx[c], volume_high[c]);
                srv = m_pend[c] && !fr;
                e_new[c] = srv;
                e_dma[c] = srv && (pre < LVL);
                if (fr) begin
                    mq[c].delete();
                    m_idx[c] = 0; e_ovf[c] = 0; e_und[c] = 0;
                    m_pend[c] = m_pend[c] | tk;
                end else begin
                    if (srv && pre == 0 && e_und[c] < 255) e_und[c]++;
                    if (srv) begin
                        if (m_idx[c] < 3) m_idx[c]++;
                        else if (pre > 0) begin
                            m_cur[c] = mq[c].pop_front();
                            m_idx[c] = 0;
                        end
                    end
                    if (wr) begin
                        if (pre == DEPTH) begin
                            mq[c].delete();
                            e_ovf[c] = 1;
                        end
                        mq[c].push_back(wif.wr_data);
                    end
                    m_pend[c] = tk;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("sample_out[%0d]", c), int'($signed(sample_out[c])), e_samp[c]);
            chk($sformatf("new_sample[%0d]", c), int'(new_sample[c]), int'(e_new[c]));
            chk($sformatf("dma_req[%0d]", c), int'(dma_req[c]), int'(e_dma[c]));
            chk($sformatf("fifo_count[%0d]", c), int'(fifo_count[c]), mq[c].size());
`ifdef SOUND_DMA_STATS_EN
            chk($sformatf("underrun_cnt[%0d]", c), int'(underrun_cnt[c]), e_und[c]);
            chk($sformatf("overflow[%0d]", c), int'(overflow[c]), int'(e_ovf[c]));
`endif
        end
        chk("sound_left", int'(sound_left), e_l);
        chk("sound_right", int'(sound_right), e_r);
    end

    int dma0_cnt = 0;
    always @(negedge clk) if (dma_req[0]) dma0_cnt++;

    // ---------------- stimulus ----------------
    task automatic wr(input int ch, input logic [31:0] d);
        @(negedge clk);
        wif.wr_en = 1'b1; wif.wr_ch = 2'(ch); wif.wr_data = d; wif.wr_be = 4'hF;
        @(negedge clk);
        wif.wr_en = 1'b0;
    endtask

    // one tick pulse, then wait until sample_out and the mix have settled
    task automatic tick(input logic t0, input logic t1);
        @(negedge clk);
        timer0_tick = t0; timer1_tick = t1;
        @(negedge clk);
        timer0_tick = 1'b0; timer1_tick = 1'b0;
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic frst(input logic [NCH-1:0] m);
        @(negedge clk);
        settings_new = 1'b1; fifo_reset = m;
        @(negedge clk);
        settings_new = 1'b0; fifo_reset = '0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

    initial begin
        int base, exp_pb [4];
        wif.wr_en = 1'b0; wif.wr_ch = '0; wif.wr_data = '0; wif.wr_be = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_count0", int'(fifo_count[0]), 0);
        chk("rst_sample0", int'($signed(sample_out[0])), 0);
        reset_n = 1'b1;

        // playback, half then full volume
        en_left = 2'b11; timer_sel = 2'b10;
        wr(0, 32'h0403_0201);
        repeat (3) tick(1, 0);
        exp_pb = '{2, 4, 6, 8};
        for (int i = 0; i < 4; i++) begin
            tick(1, 0);
            chk($sformatf("play_lo%0d", i), int'($signed(sample_out[0])), exp_pb[i]);
        end
        volume_high = 2'b01;
        wr(0, 32'h80FF_7F10);
        exp_pb = '{64, 508, -4, -512};
        for (int i = 0; i < 4; i++) begin
            tick(1, 0);
            chk($sformatf("play_hi%0d", i), int'($signed(sample_out[0])), exp_pb[i]);
        end
        tick(1, 0);
        chk("underrun_repeat", int'($signed(sample_out[0])), -512);
        chk("mix_single", int'(sound_left), -512);

        // DMA refill level
        frst(2'b01);
        chk("dma_frst_count", int'(fifo_count[0]), 0);
        for (int i = 1; i <= 8; i++) wr(0, 32'h0101_0101 * i);
        #1;
        chk("dma_full_count", int'(fifo_count[0]), 8);
        base = dma0_cnt;
        repeat (32) tick(1, 0);
        chk("dma_pulses", dma0_cnt - base, 12);
        chk("dma_end_count", int'(fifo_count[0]), 0);

        // overflow on ch1
        for (int i = 1; i <= 9; i++) wr(1, 32'(i));
        #1;
        chk("ovf_count", int'(fifo_count[1]), 1);
`ifdef SOUND_DMA_STATS_EN
        chk("ovf_flag", int'(overflow[1]), 1);
`endif
        repeat (4) tick(0, 1);
        chk("ovf_head", int'($signed(sample_out[1])), 18);
        chk("ovf_drain", int'(fifo_count[1]), 0);
        wr(3, 32'hDEAD_BEEF);
        #1;
        chk("bad_ch0", int'(fifo_count[0]), 0);
        chk("bad_ch1", int'(fifo_count[1]), 0);

        // simultaneous write and pop at count 2
        frst(2'b01);
        wr(0, 32'd5);
        wr(0, 32'd6);
        repeat (3) tick(1, 0);
        @(negedge clk);
        timer0_tick = 1'b1;
        @(negedge clk);
        timer0_tick = 1'b0;
        wif.wr_en = 1'b1; wif.wr_ch = 2'd0; wif.wr_data = 32'd7; wif.wr_be = 4'hF;
        @(negedge clk);
        wif.wr_en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("wrpop_count", int'(fifo_count[0]), 2);
        chk("wrpop_head", int'($signed(sample_out[0])), 20);

        // mix of two full-scale negative channels
        frst(2'b11);
        wr(0, 32'h8080_8080);
        wr(1, 32'h8080_8080);
        volume_high = 2'b11; en_right = 2'b10;
        repeat (4) tick(1, 1);
        chk("mix_left", int'(sound_left), -1024);
        chk("mix_right", int'(sound_right), -512);
        wr(0, 32'h0101_0101);
        @(negedge clk);
        settings_new = 1'b1; fifo_reset = 2'b01;
        wif.wr_en = 1'b1; wif.wr_ch = 2'd0; wif.wr_data = 32'h1234_5678; wif.wr_be = 4'hF;
        @(negedge clk);
        settings_new = 1'b0; fifo_reset = '0; wif.wr_en = 1'b0;
        #1;
        chk("frst_wins", int'(fifo_count[0]), 0);

        // asynchronous reset mid-stream
        wr(1, 32'h0202_0202);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_left", int'(sound_left), 0);
        chk("arst_sample0", int'($signed(sample_out[0])), 0);
        chk("arst_count1", int'(fifo_count[1]), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("post_rst_count1", int'(fifo_count[1]), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
